sci_master: RTL and testbench

Serial Configuration Interface (SCI) initiator that turns parallel host read/write requests into bit-serial SCI frames. It drives the per-peripheral chip-selects and request line shared by neuron/layer SCI responders, and collects their acknowledge and serial read data. It sits between the configuration host (register file or test controller) and the `SCI_CSN`/`SCI_REQ`/`SCI_RESP`/`SCI_ACK` bus of the network layers.

---
 rtl/sci_master.sv | 182 ++++++++++++++++++
 tb/tb_sci_master.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sci_master.sv
// SCI initiator: serialises host read/write requests into SCI frames and collects ACK/read data.
// Optional ACK timeout is enabled by defining SCI_MASTER_TIMEOUT_EN.
module sci_master #(
  parameter int NUM_PERIPHERALS = 1,
  parameter int ADDR_WIDTH      = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES  = 64,
  localparam int DEST_WIDTH     = (NUM_PERIPHERALS > 1) ? $clog2(NUM_PERIPHERALS) : 1
) (
  input  logic                       CLK,
  input  logic                       RSTN,
  input  logic                       REQ,
  input  logic                       WNR,
  input  logic [DEST_WIDTH-1:0]      DEST,
  input  logic [ADDR_WIDTH-1:0]      ADDR,
  input  logic [DATA_WIDTH-1:0]      DATA_IN,
  output logic                       READY,
  output logic [DATA_WIDTH-1:0]      DATA_OUT,
  output logic                       DATA_VALID,
  output logic                       DONE,
  output logic                       ERROR,
  output logic [NUM_PERIPHERALS-1:0] SCI_CSN,
  output logic                       SCI_REQ,
  input  logic                       SCI_RESP,
  input  logic                       SCI_ACK
);

  localparam int SHIFT_WIDTH = ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_WIDTH   = $clog2(SHIFT_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_WDATA,
    S_WAIT_ACK,
    S_RDATA,
    S_END
  } state_t;

  state_t                 state;
  logic                   wnr_q;
  logic [SHIFT_WIDTH-1:0] shift_q;
  logic [CNT_WIDTH-1:0]   bit_cnt;
  logic [DATA_WIDTH-1:0]  rx_q;
  logic [DATA_WIDTH-1:0]  rx_next;
  logic [NUM_PERIPHERALS-1:0] csn_sel;
  logic                   dest_bad;
  logic                   tmo_hit;

  assign rx_next  = (rx_q << 1) | DATA_WIDTH'(SCI_RESP);
  assign dest_bad = 32'(DEST) >= 32'(NUM_PERIPHERALS);

  always_comb begin
    csn_sel = '1;
    for (int i = 0; i < NUM_PERIPHERALS; i++) begin
      if (32'(DEST) == 32'(i)) csn_sel[i] = 1'b0;
    end
  end

`ifdef SCI_MASTER_TIMEOUT_EN
  localparam int TMO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_WIDTH-1:0] tmo_cnt;

  // Counts consecutive ACK-less cycles while waiting on the responder.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      tmo_cnt <= '0;
    end else if ((state == S_WAIT_ACK || state == S_RDATA) && !SCI_ACK) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign tmo_hit = (state == S_WAIT_ACK || state == S_RDATA) && !SCI_ACK &&
                   (tmo_cnt == TMO_WIDTH'(TIMEOUT_CYCLES - 1));
`else
  // Without the timeout the master waits forever; this expression is always false.
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= S_IDLE;
      READY      <= 1'b1;
      SCI_CSN    <= '1;
      SCI_REQ    <= 1'b0;
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
      DONE       <= 1'b0;
      ERROR      <= 1'b0;
      wnr_q      <= 1'b0;
      shift_q    <= '0;
      bit_cnt    <= '0;
      rx_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (REQ) begin
            READY   <= 1'b0;
            wnr_q   <= WNR;
            shift_q <= {ADDR, DATA_IN};
            rx_q    <= '0;
            if (dest_bad) begin
              state <= S_END;
              DONE  <= 1'b1;
              ERROR <= 1'b1;
            end else begin
              state   <= S_HDR;
              SCI_CSN <= csn_sel;
              SCI_REQ <= WNR;
              bit_cnt <= CNT_WIDTH'(ADDR_WIDTH);
            end
          end
        end
        // bit_cnt holds how many bits of the current field remain after the one on the wire.
        S_HDR: begin
          if (bit_cnt != '0) begin
            SCI_REQ <= shift_q[SHIFT_WIDTH-1];
            shift_q <= shift_q << 1;
            bit_cnt <= bit_cnt - 1'b1;
          end else if (wnr_q) begin
            state   <= S_WDATA;
            SCI_REQ <= shift_q[SHIFT_WIDTH-1];
            shift_q <= shift_q << 1;
            bit_cnt <= CNT_WIDTH'(DATA_WIDTH - 1);
          end else begin
            state   <= S_WAIT_ACK;
            SCI_REQ <= 1'b0;
            bit_cnt <= '0;
          end
        end
        S_WDATA: begin
          if (bit_cnt != '0) begin
            SCI_REQ <= shift_q[SHIFT_WIDTH-1];
            shift_q <= shift_q << 1;
            bit_cnt <= bit_cnt - 1'b1;
          end else begin
            state   <= S_WAIT_ACK;
            SCI_REQ <= 1'b0;
            bit_cnt <= '0;
          end
        end
        S_WAIT_ACK, S_RDATA: begin
          if (SCI_ACK) begin
            if (wnr_q) begin
              state   <= S_END;
              DONE    <= 1'b1;
              SCI_CSN <= '1;
            end else begin
              rx_q <= rx_next;
              if (bit_cnt == CNT_WIDTH'(DATA_WIDTH - 1)) begin
                state      <= S_END;
                DONE       <= 1'b1;
                DATA_VALID <= 1'b1;
                DATA_OUT   <= rx_next;
                SCI_CSN    <= '1;
              end else begin
                state   <= S_RDATA;
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end else if (tmo_hit) begin
            state   <= S_END;
            DONE    <= 1'b1;
            ERROR   <= 1'b1;
            SCI_CSN <= '1;
          end
        end
        S_END: begin
          state      <= S_IDLE;
          DONE       <= 1'b0;
          ERROR      <= 1'b0;
          DATA_VALID <= 1'b0;
          READY      <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sci_master.sv
// Directed self-checking bench for sci_master with five responders, 4-bit address and 8-bit data.
module tb_sci_master;

  localparam int NUM = 5;
  localparam int TMO = 64;

  logic       clk;
  logic       rst_n;
  logic       req;
  logic       wnr;
  logic [2:0] dest;
  logic [3:0] addr;
  logic [7:0] data_in;
  logic       ready;
  logic [7:0] data_out;
  logic       data_valid;
  logic       done;
  logic       error;
  logic [4:0] sci_csn;
  logic       sci_req;
  logic       sci_resp;
  logic       sci_ack;

  int checks   = 0;
  int failures = 0;

  sci_master #(
    .NUM_PERIPHERALS(NUM),
    .ADDR_WIDTH(4),
    .DATA_WIDTH(8),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(clk),
    .RSTN(rst_n),
    .REQ(req),
    .WNR(wnr),
    .DEST(dest),
    .ADDR(addr),
    .DATA_IN(data_in),
    .READY(ready),
    .DATA_OUT(data_out),
    .DATA_VALID(data_valid),
    .DONE(done),
    .ERROR(error),
    .SCI_CSN(sci_csn),
    .SCI_REQ(sci_req),
    .SCI_RESP(sci_resp),
    .SCI_ACK(sci_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic w, input logic [2:0] d, input logic [3:0] a, input logic [7:0] di);
    req     = 1'b1;
    wnr     = w;
    dest    = d;
    addr    = a;
    data_in = di;
  endtask

  // Checks one frame bit per cycle starting with the current cycle; ends on the last bit's cycle.
  task automatic check_frame(input string tag, input logic [12:0] frame, input int len, input logic [4:0] csn_exp);
    for (int i = 0; i < len; i++) begin
      if (i > 0) tick();
      checkOutput($sformatf("%s_bit%0d", tag, i), sci_req, frame[len-1-i]);
      checkOutput($sformatf("%s_csn%0d", tag, i), sci_csn, csn_exp);
    end
  endtask

  // From the last frame cycle: wait ack_wait cycles, ACK once, check END and the return to READY.
  task automatic finish_write(input string tag, input int ack_wait, input logic [4:0] csn_exp);
    tick();
    checkOutput({tag, "_req_low"}, sci_req, 1'b0);
    checkOutput({tag, "_csn_wait"}, sci_csn, csn_exp);
    checkOutput({tag, "_no_done"}, done, 1'b0);
    repeat (ack_wait - 1) tick();
    sci_ack = 1'b1;
    tick();
    sci_ack = 1'b0;
    checkOutput({tag, "_done"}, done, 1'b1);
    checkOutput({tag, "_error"}, error, 1'b0);
    checkOutput({tag, "_csn_end"}, sci_csn, 5'b11111);
    checkOutput({tag, "_busy_end"}, ready, 1'b0);
    tick();
    checkOutput({tag, "_ready"}, ready, 1'b1);
    checkOutput({tag, "_done_clr"}, done, 1'b0);
  endtask

  initial begin
    int wait_cycles;
    int done_seen;
    logic [8:0] rd_ack;
    logic [8:0] rd_resp;

    rst_n = 1'b0; req = 1'b0; wnr = 1'b0; dest = '0; addr = '0; data_in = '0;
    sci_resp = 1'b0; sci_ack = 1'b0;
    repeat (2) tick();
    checkOutput("rst_ready", ready, 1'b1);
    checkOutput("rst_csn", sci_csn, 5'b11111);
    checkOutput("rst_req", sci_req, 1'b0);
    checkOutput("rst_dout", data_out, 8'h00);
    checkOutput("rst_dvalid", data_valid, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_error", error, 1'b0);
    rst_n = 1'b1;
    tick();

    // Write DEST=2 ADDR=A DATA=5C, ACK at cycle 16.
    applyStimulus(1'b1, 3'd2, 4'hA, 8'h5C);
    tick();
    req = 1'b0;
    check_frame("wr1", 13'b1_1010_01011100, 13, 5'b11011);
    finish_write("wr1", 3, 5'b11011);

    // Read DEST=0 ADDR=3, responder returns A7 with a stall after bit 4.
    applyStimulus(1'b0, 3'd0, 4'h3, 8'h00);
    tick();
    req = 1'b0;
    check_frame("rd", 13'b0_0000_0000_0011, 5, 5'b11110);
    tick();
    checkOutput("rd_req_low", sci_req, 1'b0);
    checkOutput("rd_csn_wait", sci_csn, 5'b11110);
    tick();
    rd_ack  = 9'b111101111;
    rd_resp = 9'b101010111;
    for (int i = 0; i < 9; i++) begin
      sci_ack  = rd_ack[8-i];
      sci_resp = rd_resp[8-i];
      checkOutput($sformatf("rd_dvalid_early%0d", i), data_valid, 1'b0);
      tick();
    end
    sci_ack = 1'b0; sci_resp = 1'b0;
    checkOutput("rd_dvalid", data_valid, 1'b1);
    checkOutput("rd_dout", data_out, 8'hA7);
    checkOutput("rd_done", done, 1'b1);
    checkOutput("rd_error", error, 1'b0);
    checkOutput("rd_csn_end", sci_csn, 5'b11111);
    tick();
    checkOutput("rd_dvalid_clr", data_valid, 1'b0);
    checkOutput("rd_dout_hold", data_out, 8'hA7);
    checkOutput("rd_ready", ready, 1'b1);

    // Out-of-range DEST=5.
    applyStimulus(1'b1, 3'd5, 4'h1, 8'h11);
    tick();
    req = 1'b0;
    checkOutput("bad_done", done, 1'b1);
    checkOutput("bad_error", error, 1'b1);
    checkOutput("bad_csn", sci_csn, 5'b11111);
    checkOutput("bad_busy", ready, 1'b0);
    tick();
    checkOutput("bad_ready", ready, 1'b1);
    checkOutput("bad_done_clr", done, 1'b0);
    checkOutput("bad_dout_hold", data_out, 8'hA7);

    // Write DEST=1 never ACKed.
    applyStimulus(1'b1, 3'd1, 4'h3, 8'h11);
    tick();
    req = 1'b0;
    check_frame("tmo", 13'b1_0011_00010001, 13, 5'b11101);
`ifdef SCI_MASTER_TIMEOUT_EN
    wait_cycles = 0;
    do begin
      tick();
      wait_cycles++;
    end while (!done && wait_cycles < 200);
    checkOutput("tmo_latency", wait_cycles, 1 + TMO);
    checkOutput("tmo_error", error, 1'b1);
    checkOutput("tmo_csn", sci_csn, 5'b11111);
    checkOutput("tmo_dvalid", data_valid, 1'b0);
    checkOutput("tmo_dout_hold", data_out, 8'hA7);
    tick();
    checkOutput("tmo_ready", ready, 1'b1);
`else
    done_seen = 0;
    repeat (1000) begin
      tick();
      if (done) done_seen++;
    end
    checkOutput("tmo_no_done", done_seen, 0);
    checkOutput("tmo_csn_held", sci_csn, 5'b11101);
    checkOutput("tmo_busy", ready, 1'b0);
    sci_ack = 1'b1;
    tick();
    sci_ack = 1'b0;
    checkOutput("tmo_late_done", done, 1'b1);
    checkOutput("tmo_late_error", error, 1'b0);
    tick();
    checkOutput("tmo_ready", ready, 1'b1);
`endif

    // Reset asserted during WDATA of a DEST=3 write.
    applyStimulus(1'b1, 3'd3, 4'hF, 8'hFF);
    tick();
    req = 1'b0;
    checkOutput("rstw_csn_low", sci_csn, 5'b10111);
    repeat (7) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstw_csn", sci_csn, 5'b11111);
    checkOutput("rstw_req", sci_req, 1'b0);
    checkOutput("rstw_ready", ready, 1'b1);
    checkOutput("rstw_dout", data_out, 8'h00);
    done_seen = 0;
    repeat (2) begin
      tick();
      if (done) done_seen++;
    end
    checkOutput("rstw_no_done", done_seen, 0);
    rst_n = 1'b1;
    tick();
    applyStimulus(1'b1, 3'd4, 4'h5, 8'h3C);
    tick();
    req = 1'b0;
    check_frame("post", 13'b1_0101_00111100, 13, 5'b01111);
    finish_write("post", 1, 5'b01111);

    // Back-to-back writes with REQ held high.
    applyStimulus(1'b1, 3'd0, 4'h1, 8'h81);
    tick();
    applyStimulus(1'b1, 3'd2, 4'hE, 8'h42);
    check_frame("b2b1", 13'b1_0001_10000001, 13, 5'b11110);
    tick();
    sci_ack = 1'b1;
    tick();
    sci_ack = 1'b0;
    checkOutput("b2b1_done", done, 1'b1);
    checkOutput("b2b_gap1", sci_csn, 5'b11111);
    tick();
    checkOutput("b2b_gap2", sci_csn, 5'b11111);
    checkOutput("b2b_ready", ready, 1'b1);
    tick();
    req = 1'b0;
    check_frame("b2b2", 13'b1_1110_01000010, 13, 5'b11011);
    finish_write("b2b2", 1, 5'b11011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
